// File: rtl/sram_dp_param.sv
// Simple dual-port SRAM (one write port, one read port) with per-word written flags,
// selectable read latency (1 or 2) and write-first/read-first collision behaviour.
module sram_dp_param #(
    parameter int unsigned WIDTH       = 264,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned AW          = 7,
    parameter int unsigned RD_LAT      = 1,
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             W,
    input  logic             R,
    input  logic [AW-1:0]    WA,
    input  logic [AW-1:0]    RA,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             DoutValid,
    output logic             RdErr,
    output logic             Collision
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written_q;

    logic             wa_ok;
    logic             ra_ok;
    logic             rd_coll;
    logic             rd_err;
    logic [WIDTH-1:0] rd_data;

    logic             fin_valid;
    logic             fin_err;
    logic             fin_coll;
    logic [WIDTH-1:0] fin_data;

    logic             valid_q;
    logic             err_q;
    logic             coll_q;
    logic [WIDTH-1:0] dout_q;

    assign wa_ok = (32'(WA) < DEPTH);
    assign ra_ok = (32'(RA) < DEPTH);

    // Array is deliberately not reset; the written flags mask stale contents instead.
    always_ff @(posedge CLK) begin
        if (RSTB && W && wa_ok) begin
            mem[WA] <= Din;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            written_q <= '0;
        end else if (W && wa_ok) begin
            written_q[WA] <= 1'b1;
        end
    end

    // Read result is resolved at capture against the pre-write array and flags.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        rd_coll = R && W && wa_ok && (WA == RA);
        if (rd_coll && WRITE_FIRST) begin
            rd_data = Din;
        end else if (!ra_ok || !written_q[RA]) begin
            rd_err = 1'b1;
        end else begin
            rd_data = mem[RA];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic             p_valid_q;
        logic             p_err_q;
        logic             p_coll_q;
        logic [WIDTH-1:0] p_data_q;

        always_ff @(posedge CLK or negedge RSTB) begin
            if (!RSTB) begin
                p_valid_q <= 1'b0;
                p_err_q   <= 1'b0;
                p_coll_q  <= 1'b0;
                p_data_q  <= '0;
            end else begin
                p_valid_q <= R;
                if (R) begin
                    p_err_q  <= rd_err;
                    p_coll_q <= rd_coll;
                    p_data_q <= rd_data;
                end
            end
        end

        assign fin_valid = p_valid_q;
        assign fin_err   = p_err_q;
        assign fin_coll  = p_coll_q;
        assign fin_data  = p_data_q;
    end else begin : g_lat1
        assign fin_valid = R;
        assign fin_err   = rd_err;
        assign fin_coll  = rd_coll;
        assign fin_data  = rd_data;
    end

    // Output register holds its value between completed reads.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            coll_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= fin_valid;
            if (fin_valid) begin
                err_q  <= fin_err;
                coll_q <= fin_coll;
                dout_q <= fin_data;
            end
        end
    end

    assign Dout      = dout_q;
    assign DoutValid = valid_q;
    assign RdErr     = err_q;
    assign Collision = coll_q;

endmodule

// File: tb/tb_sram_dp_param.sv
// Scoreboard bench: config A (DEPTH=128, RD_LAT=1, read-first) and config B (DEPTH=100,
// RD_LAT=2, write-first) share one directed stimulus stream.
module tb_sram_dp_param;

    localparam int unsigned WIDTH = 264;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct {
        word_t d;
        logic  e;
        logic  c;
    } exp_t;
    typedef struct {
        word_t       d;
        logic        e;
        logic        c;
        int unsigned due;
    } sb_t;

    logic       clk  = 1'b0;
    logic       rstb = 1'b1;
    logic       w    = 1'b0;
    logic       r    = 1'b0;
    logic [6:0] wa   = '0;
    logic [6:0] ra   = '0;
    word_t      din  = '0;

    word_t dout_a, dout_b;
    logic  vld_a, vld_b, err_a, err_b, coll_a, coll_b;

    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    sb_t   qa[$];
    sb_t   qb[$];
    word_t last_d [2];
    logic  last_e [2];
    logic  last_c [2];

    sram_dp_param #(
        .WIDTH(WIDTH), .DEPTH(128), .AW(7), .RD_LAT(1), .WRITE_FIRST(1'b0)
    ) u_a (
        .CLK(clk), .RSTB(rstb), .W(w), .R(r), .WA(wa), .RA(ra), .Din(din),
        .Dout(dout_a), .DoutValid(vld_a), .RdErr(err_a), .Collision(coll_a)
    );

    sram_dp_param #(
        .WIDTH(WIDTH), .DEPTH(100), .AW(7), .RD_LAT(2), .WRITE_FIRST(1'b1)
    ) u_b (
        .CLK(clk), .RSTB(rstb), .W(w), .R(r), .WA(wa), .RA(ra), .Din(din),
        .Dout(dout_b), .DoutValid(vld_b), .RdErr(err_b), .Collision(coll_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic word_t wd(input logic [7:0] b);
        return {256'd0, b};
    endfunction

    function automatic exp_t ex(input word_t d, input logic e, input logic c);
        exp_t x;
        x.d = d;
        x.e = e;
        x.c = c;
        return x;
    endfunction

    function automatic exp_t ok(input word_t d);
        return ex(d, 1'b0, 1'b0);
    endfunction

    function automatic exp_t bad();
        return ex('0, 1'b1, 1'b0);
    endfunction

    // Compare one DUT's outputs against the scoreboard entry due this cycle, or hold values.
    task automatic mon(input int i, input logic v, input word_t d, input logic e, input logic c);
        sb_t   s;
        bit    hit;
        string p;
        hit = 1'b0;
        p   = (i == 0) ? "a" : "b";
        if (i == 0) begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                s   = qa.pop_front();
                hit = 1'b1;
            end
        end else begin
            if (qb.size() > 0 && qb[0].due == cyc) begin
                s   = qb.pop_front();
                hit = 1'b1;
            end
        end
        if (hit) begin
            chk({p, ".valid"}, word_t'(v), word_t'(1'b1));
            chk({p, ".dout"}, d, s.d);
            chk({p, ".rderr"}, word_t'(e), word_t'(s.e));
            chk({p, ".coll"}, word_t'(c), word_t'(s.c));
            last_d[i] = s.d;
            last_e[i] = s.e;
            last_c[i] = s.c;
        end else begin
            chk({p, ".idle_valid"}, word_t'(v), '0);
            chk({p, ".hold_dout"}, d, last_d[i]);
            chk({p, ".hold_rderr"}, word_t'(e), word_t'(last_e[i]));
            chk({p, ".hold_coll"}, word_t'(c), word_t'(last_c[i]));
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon(0, vld_a, dout_a, err_a, coll_a);
        mon(1, vld_b, dout_b, err_b, coll_b);
    end

    task automatic op(input logic wv, input logic [6:0] wad, input word_t dv,
                      input logic rv, input logic [6:0] rad, input exp_t ea, input exp_t eb);
        sb_t s;
        @(negedge clk);
        w   = wv;
        wa  = wad;
        din = dv;
        r   = rv;
        ra  = rad;
        if (rv) begin
            s.d = ea.d; s.e = ea.e; s.c = ea.c; s.due = cyc + 1;
            qa.push_back(s);
            s.d = eb.d; s.e = eb.e; s.c = eb.c; s.due = cyc + 2;
            qb.push_back(s);
        end
    endtask

    task automatic wr(input logic [6:0] a, input word_t d);
        op(1'b1, a, d, 1'b0, 7'd0, bad(), bad());
    endtask

    task automatic rd(input logic [6:0] a, input exp_t ea, input exp_t eb);
        op(1'b0, 7'd0, '0, 1'b1, a, ea, eb);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) op(1'b0, 7'd0, '0, 1'b0, 7'd0, bad(), bad());
    endtask

    task automatic clear_sb();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            last_d[k] = '0;
            last_e[k] = 1'b0;
            last_c[k] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("a.rst_dout", dout_a, '0);
        chk("a.rst_valid", word_t'(vld_a), '0);
        chk("a.rst_rderr", word_t'(err_a), '0);
        chk("a.rst_coll", word_t'(coll_a), '0);
        chk("b.rst_dout", dout_b, '0);
        chk("b.rst_valid", word_t'(vld_b), '0);
        chk("b.rst_rderr", word_t'(err_b), '0);
        chk("b.rst_coll", word_t'(coll_b), '0);
    endtask

    initial begin
        word_t pat;
        pat = {33{8'hA5}};
        clear_sb();
        #2 rstb = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        #1 rstb = 1'b1;

        // Basic path and uninitialised read
        wr(7'd5, pat);
        rd(7'd5, ok(pat), ok(pat));
        rd(7'd9, bad(), bad());

        // Range: 120 is valid for A only
        wr(7'd120, wd(8'h77));
        rd(7'd120, ok(wd(8'h77)), bad());
        op(1'b1, 7'd120, wd(8'h99), 1'b1, 7'd120, ex(wd(8'h77), 1'b0, 1'b1), bad());
        rd(7'd120, ok(wd(8'h99)), bad());

        // Collisions: A returns old data, B returns new data
        wr(7'd3, wd(8'h11));
        op(1'b1, 7'd3, wd(8'h22), 1'b1, 7'd3,
           ex(wd(8'h11), 1'b0, 1'b1), ex(wd(8'h22), 1'b0, 1'b1));
        rd(7'd3, ok(wd(8'h22)), ok(wd(8'h22)));
        op(1'b1, 7'd7, wd(8'h33), 1'b1, 7'd7, ex('0, 1'b1, 1'b1), ex(wd(8'h33), 1'b0, 1'b1));

        // Concurrent write and read to different addresses
        op(1'b1, 7'd10, wd(8'h55), 1'b1, 7'd3, ok(wd(8'h22)), ok(wd(8'h22)));
        rd(7'd10, ok(wd(8'h55)), ok(wd(8'h55)));

        // Streaming
        for (int i = 0; i < 8; i++) wr(7'(i), wd(8'(8'h40 + i)));
        for (int i = 0; i < 8; i++) rd(7'(i), ok(wd(8'(8'h40 + i))), ok(wd(8'(8'h40 + i))));

        // Top-of-range boundaries
        wr(7'd99, wd(8'hC3));
        rd(7'd99, ok(wd(8'hC3)), ok(wd(8'hC3)));
        wr(7'd127, wd(8'hD4));
        rd(7'd127, ok(wd(8'hD4)), bad());

        // Hold across idle cycles, including writes that must not disturb Dout
        rd(7'd2, ok(wd(8'h42)), ok(wd(8'h42)));
        for (int i = 0; i < 5; i++) op(1'b1, 7'd2, wd(8'hFF), 1'b0, 7'd0, bad(), bad());
        rd(7'd2, ok(wd(8'hFF)), ok(wd(8'hFF)));
        idle(3);

        // Reset while B's read is in its pipeline stage
        rd(7'd6, ok(wd(8'h46)), ok(wd(8'h46)));
        @(negedge clk);
        #1;
        rstb = 1'b0;
        clear_sb();
        w = 1'b1; wa = 7'd6; din = wd(8'hEE); r = 1'b1; ra = 7'd6;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        #1;
        rstb = 1'b1;
        w = 1'b0;
        r = 1'b0;
        idle(2);
        rd(7'd6, bad(), bad());
        rd(7'd5, bad(), bad());
        wr(7'd5, wd(8'h12));
        rd(7'd5, ok(wd(8'h12)), ok(wd(8'h12)));

        idle(4);
        chk("drain", word_t'(qa.size() + qb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
